// File: rtl/if_inst_responder_pkg.sv
// Shared types and bus macros for the instruction-memory responder.
// Combinational helpers only; no latency.
// No flow control here; used by the responder and its response FIFO.
`ifndef IF_INST_DEFINES
`define IF_INST_DEFINES
`define INST_BUS 31:0
`define INST_NOP 32'h0000_0013
`define REG_BUS 63:0
`define ZERO_WORD 64'h0000_0000_0000_0000
`endif

package if_inst_responder_pkg;

    typedef struct packed {
        logic             err;
        logic [`REG_BUS]  pc;
        logic [`INST_BUS] inst;
    } resp_t;

    localparam int RESP_W = $bits(resp_t);

    // Selects the 32-bit instruction half of a 64-bit array word.
    function automatic logic [`INST_BUS] pick_half(input logic [`REG_BUS] word, input logic hi);
        return hi ? word[63:32] : word[31:0];
    endfunction

endpackage

// File: rtl/if_inst_responder_fifo.sv
// Response FIFO: DEPTH entries of {err, pc, inst}, head read straight from storage.
// Latency: a push is visible at the head the cycle after its edge.
// Backpressure: push is dropped when full and pop ignored when empty; flush empties it.
module if_resp_fifo
    import if_inst_responder_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              push,
    input  logic [RESP_W-1:0] push_dat,
    input  logic              pop,
    output logic [RESP_W-1:0] head_dat,
    output logic              empty,
    output logic              full
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [RESP_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     cnt;
    logic              do_push;
    logic              do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty    = (cnt == '0);
    assign full     = (cnt == CW'(DEPTH));
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            cnt <= cnt + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage is not reset: the top masks the head whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/if_inst_responder.sv
// Instruction-memory responder: 64-bit word array, fixed-latency read pipe, in-order response FIFO.
// Latency: response visible LATENCY-1 edges after the accept edge (next cycle for LATENCY=1).
// Backpressure: credit counter covers in-flight + buffered entries; req_ready is from registers only.
module if_inst_responder
    import if_inst_responder_pkg::*;
#(
    parameter logic [63:0] ADDR_BASE   = 64'h0000_0000_8000_0000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 2,
    parameter int          FIFO_DEPTH  = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush,
    input  logic                           req_valid,
    input  logic [63:0]                    req_pc,
    output logic                           req_ready,
    output logic                           resp_valid,
    input  logic                           resp_ready,
    output logic [31:0]                    resp_inst,
    output logic [63:0]                    resp_pc,
    output logic                           resp_err,
    input  logic                           ld_en,
    input  logic [$clog2(DEPTH_WORDS)-1:0] ld_addr,
    input  logic [63:0]                    ld_data
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int CW    = $clog2(FIFO_DEPTH + 1);

    logic [63:0]       mem [DEPTH_WORDS];
    logic [CW-1:0]     cnt;
    logic              acc;
    logic              pop;
    logic [63:0]       off_words;
    logic [IDX_W-1:0]  word_idx;
    logic [63:0]       rd_word;
    logic              fetch_err;
    resp_t             acc_dat;
    logic              push_vld;
    resp_t             push_dat;
    logic [RESP_W-1:0] fifo_head;
    resp_t             head;
    logic              fifo_empty;
    logic              fifo_full;

    assign req_ready = (cnt < CW'(FIFO_DEPTH)) && !fifo_full;
    assign acc       = req_valid && req_ready && !flush;
    assign pop       = resp_valid && resp_ready && !flush;

    // Addresses below ADDR_BASE wrap to huge offsets, but are flagged explicitly anyway.
    assign off_words = (req_pc - ADDR_BASE) >> 3;
    assign word_idx  = off_words[IDX_W-1:0];
    assign fetch_err = (|req_pc[1:0]) || (req_pc < ADDR_BASE) || (off_words >= 64'(DEPTH_WORDS));
    assign rd_word   = mem[word_idx];

    always_comb begin
        acc_dat      = '0;
        acc_dat.err  = fetch_err;
        acc_dat.pc   = req_pc;
        acc_dat.inst = fetch_err ? `INST_NOP : pick_half(rd_word, req_pc[2]);
    end

    // The read above sees pre-edge contents, so a same-edge load returns old data.
    always_ff @(posedge clk) begin
        if (ld_en) mem[ld_addr] <= ld_data;
    end

    generate
        if (LATENCY == 1) begin : g_direct
            assign push_vld = acc;
            assign push_dat = acc_dat;
        end else begin : g_pipe
            logic [LATENCY-2:0] vld;
            resp_t              dat [LATENCY-1];

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    vld <= '0;
                    for (int i = 0; i < LATENCY - 1; i++) dat[i] <= '0;
                end else if (flush) begin
                    vld <= '0;
                end else begin
                    vld[0] <= acc;
                    dat[0] <= acc_dat;
                    for (int i = 1; i < LATENCY - 1; i++) begin
                        vld[i] <= vld[i-1];
                        dat[i] <= dat[i-1];
                    end
                end
            end

            assign push_vld = vld[LATENCY-2];
            assign push_dat = dat[LATENCY-2];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)       cnt <= '0;
        else if (flush) cnt <= '0;
        else            cnt <= cnt + CW'(acc) - CW'(pop);
    end

    if_resp_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .push     (push_vld),
        .push_dat (push_dat),
        .pop      (pop),
        .head_dat (fifo_head),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

    // Outputs come from FIFO storage registers, masked to zero while empty.
    assign head       = fifo_head;
    assign resp_valid = !fifo_empty;
    assign resp_inst  = fifo_empty ? '0 : head.inst;
    assign resp_pc    = fifo_empty ? `ZERO_WORD : head.pc;
    assign resp_err   = fifo_empty ? 1'b0 : head.err;

endmodule

// File: tb/tb_if_inst_responder.sv
// Directed, table-driven bench for if_inst_responder with default parameters.
module tb_if_inst_responder;

    localparam int LATENCY = 2;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        req_valid;
    logic [63:0] req_pc;
    logic        req_ready;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_inst;
    logic [63:0] resp_pc;
    logic        resp_err;
    logic        ld_en;
    logic [9:0]  ld_addr;
    logic [63:0] ld_data;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
        logic        err;
    } vec_t;

    vec_t vecs [12];

    if_inst_responder dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_pc     (req_pc),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_inst  (resp_inst),
        .resp_pc    (resp_pc),
        .resp_err   (resp_err),
        .ld_en      (ld_en),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic load(input logic [9:0] a, input logic [63:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    // Single fetch with resp_ready high; optional load on the accept edge.
    task automatic fetch_one(input string nm, input logic [63:0] pc, input logic do_ld,
                             input logic [9:0] la, input logic [63:0] ldd,
                             input logic [31:0] ei, input logic ee);
        int k;
        chk({nm, "_rdy"}, req_ready, 1);
        req_valid = 1'b1; req_pc = pc; resp_ready = 1'b1;
        ld_en = do_ld; ld_addr = la; ld_data = ldd;
        @(negedge clk);
        req_valid = 1'b0; ld_en = 1'b0;
        k = 1;
        while (!resp_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk({nm, "_lat"}, 64'(k), 64'(LATENCY));
        chk({nm, "_inst"}, resp_inst, ei);
        chk({nm, "_pc"}, resp_pc, pc);
        chk({nm, "_err"}, resp_err, ee);
        @(negedge clk);
    endtask

    // Holds resp_ready low and requests every cycle; returns how many were accepted.
    task automatic fill(input logic [63:0] base, output int n);
        logic r;
        n = 0; req_valid = 1'b1; resp_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            req_pc = base + 64'(4 * n);
            r = req_ready;
            @(negedge clk);
            if (r) n++;
        end
        req_valid = 1'b0;
    endtask

    initial begin
        int          n;
        logic        quiet;
        logic [31:0] drain_exp [4];

        vecs[0]  = '{64'h0000_0000_8000_0000, 32'h0000_0013, 1'b0};
        vecs[1]  = '{64'h0000_0000_8000_0004, 32'h0010_0093, 1'b0};
        vecs[2]  = '{64'h0000_0000_8000_0008, 32'hCAFE_F00D, 1'b0};
        vecs[3]  = '{64'h0000_0000_8000_000C, 32'hDEAD_BEEF, 1'b0};
        vecs[4]  = '{64'h0000_0000_8000_1FF8, 32'h3333_4444, 1'b0};
        vecs[5]  = '{64'h0000_0000_8000_1FFC, 32'h1111_2222, 1'b0};
        vecs[6]  = '{64'h0000_0000_8000_0002, 32'h0000_0013, 1'b1};
        vecs[7]  = '{64'h0000_0000_8000_0001, 32'h0000_0013, 1'b1};
        vecs[8]  = '{64'h0000_0000_8000_2000, 32'h0000_0013, 1'b1};
        vecs[9]  = '{64'h0000_0000_7FFF_FFFC, 32'h0000_0013, 1'b1};
        vecs[10] = '{64'h0000_0000_8000_2002, 32'h0000_0013, 1'b1};
        vecs[11] = '{64'h0000_0001_8000_0000, 32'h0000_0013, 1'b1};
        drain_exp[0] = 32'h0000_0013;
        drain_exp[1] = 32'h0010_0093;
        drain_exp[2] = 32'hCAFE_F00D;
        drain_exp[3] = 32'hDEAD_BEEF;

        rst = 1'b1; flush = 1'b0; req_valid = 1'b0; req_pc = '0; resp_ready = 1'b0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        #3 rst = 1'b0;
        #2;
        chk("rst_vld", resp_valid, 0);
        chk("rst_inst", resp_inst, 0);
        chk("rst_pc", resp_pc, 0);
        chk("rst_err", resp_err, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_rdy", req_ready, 1);

        load(10'd0, 64'h0010_0093_0000_0013);
        load(10'd1, 64'hDEAD_BEEF_CAFE_F00D);
        load(10'd5, 64'hAAAA_0005_BBBB_0005);
        load(10'd1023, 64'h1111_2222_3333_4444);

        // Back-to-back fetches of both halves of word 0.
        req_valid = 1'b1; req_pc = 64'h8000_0000; resp_ready = 1'b1;
        @(negedge clk);
        chk("b2b_n1_vld", resp_valid, 0);
        req_pc = 64'h8000_0004;
        @(negedge clk);
        req_valid = 1'b0;
        chk("b2b_n2_vld", resp_valid, 1);
        chk("b2b_n2_inst", resp_inst, 32'h0000_0013);
        chk("b2b_n2_pc", resp_pc, 64'h8000_0000);
        chk("b2b_n2_err", resp_err, 0);
        @(negedge clk);
        chk("b2b_n3_vld", resp_valid, 1);
        chk("b2b_n3_inst", resp_inst, 32'h0010_0093);
        chk("b2b_n3_pc", resp_pc, 64'h8000_0004);
        @(negedge clk);
        chk("b2b_n4_vld", resp_valid, 0);

        for (int i = 0; i < 12; i++)
            fetch_one($sformatf("vec%0d", i), vecs[i].pc, 1'b0, '0, '0, vecs[i].inst, vecs[i].err);

        // Backpressure: exactly FIFO_DEPTH accepted, then in-order drain.
        fill(64'h8000_0000, n);
        chk("bp_accepted", 64'(n), 64'd4);
        chk("bp_rdy_low", req_ready, 0);
        chk("bp_head_inst", resp_inst, 32'h0000_0013);
        resp_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            chk($sformatf("drain%0d_vld", j), resp_valid, 1);
            chk($sformatf("drain%0d_inst", j), resp_inst, drain_exp[j]);
            chk($sformatf("drain%0d_pc", j), resp_pc, 64'h8000_0000 + 64'(4 * j));
            @(negedge clk);
        end
        chk("drain_empty", resp_valid, 0);
        chk("drain_rdy", req_ready, 1);

        // Flush with three outstanding and a request presented on the flush edge.
        req_valid = 1'b1; req_pc = 64'h8000_0008; resp_ready = 1'b0;
        @(negedge clk);
        req_pc = 64'h8000_000C;
        @(negedge clk);
        req_pc = 64'h8000_1FF8;
        @(negedge clk);
        chk("flush_pre_vld", resp_valid, 1);
        flush = 1'b1; req_pc = 64'h8000_1FFC;
        @(negedge clk);
        flush = 1'b0; req_valid = 1'b0;
        chk("flush_vld", resp_valid, 0);
        quiet = 1'b1; resp_ready = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (resp_valid) quiet = 1'b0;
        end
        chk("flush_quiet", quiet, 1);
        fill(64'h8000_0000, n);
        chk("flush_credit", 64'(n), 64'd4);
        chk("flush_head_inst", resp_inst, 32'h0000_0013);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush2_vld", resp_valid, 0);
        fetch_one("post_flush", 64'h8000_000C, 1'b0, '0, '0, 32'hDEAD_BEEF, 1'b0);

        // Load to word 5 on the same edge as the fetch: old data first, then new.
        fetch_one("ld_old", 64'h8000_0028, 1'b1, 10'd5, 64'h1234_5678_9ABC_DEF0, 32'hBBBB_0005, 1'b0);
        fetch_one("ld_new", 64'h8000_0028, 1'b0, '0, '0, 32'h9ABC_DEF0, 1'b0);
        fetch_one("ld_new_hi", 64'h8000_002C, 1'b0, '0, '0, 32'h1234_5678, 1'b0);

        // Asynchronous reset with two outstanding.
        req_valid = 1'b1; req_pc = 64'h8000_0000; resp_ready = 1'b0;
        @(negedge clk);
        req_pc = 64'h8000_0004;
        @(negedge clk);
        req_valid = 1'b0;
        chk("mrst_pre_vld", resp_valid, 1);
        #2 rst = 1'b0;
        #1;
        chk("mrst_vld", resp_valid, 0);
        chk("mrst_inst", resp_inst, 0);
        chk("mrst_pc", resp_pc, 0);
        chk("mrst_err", resp_err, 0);
        @(negedge clk);
        rst = 1'b1;
        chk("mrst_rdy", req_ready, 1);
        quiet = 1'b1; resp_ready = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (resp_valid) quiet = 1'b0;
        end
        chk("mrst_quiet", quiet, 1);
        fetch_one("post_rst", 64'h8000_0008, 1'b0, '0, '0, 32'hCAFE_F00D, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/if_inst_responder.md
Name: if_inst_responder

Overview:
- Instruction-memory responder: the memory-side end of the fetch interface driven by the IF stage.
- Accepts fetch requests (pc + valid/ready) and returns the 32-bit instruction, its pc and an error flag over a valid/ready response channel.
- Fixed access latency; responses are buffered so the IF stage may stall.
- Backing store is an internal 64-bit-wide array, preloaded through a load port.

Parameters:
- ADDR_BASE, 64'h0000_0000_8000_0000, byte address of array word 0.
- DEPTH_WORDS, 1024, number of 64-bit array words.
- LATENCY, 2, cycles from request-accept edge to response visible (legal 1..4).
- FIFO_DEPTH, 4, max outstanding (in-flight + buffered) requests; must be >= LATENCY for full throughput.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  sync flush of all in-flight and buffered responses.
- req_valid  in  1  fetch request valid.
- req_pc  in  64  fetch byte address.
- req_ready  out  1  request can be accepted.
- resp_valid  out  1  response at head valid.
- resp_ready  in  1  consumer takes the response.
- resp_inst  out  32  instruction.
- resp_pc  out  64  pc of the returned instruction.
- resp_err  out  1  misaligned or out-of-range fetch.
- ld_en  in  1  array write enable.
- ld_addr  in  clog2(DEPTH_WORDS)  array word index.
- ld_data  in  64  array write data.

Behaviour:
- Reset (rst==0, async): pipeline valids cleared, FIFO empty, count=0, resp_valid=0, resp_inst=0, resp_pc=0, resp_err=0; req_ready=1 after release. Array contents are not reset.
- Accept: edge where req_valid && req_ready && !flush.
- Pop: edge where resp_valid && resp_ready.
- count = in-flight + FIFO occupancy; count += accept, count -= pop, both may occur on one edge.
- req_ready = (count < FIFO_DEPTH), registered-count only. No combinational path from resp_ready or req_valid.
- Word index = (req_pc - ADDR_BASE) >> 3; resp_inst = req_pc[2] ? word[63:32] : word[31:0].
- Array read samples contents at the accept edge. A same-edge ld_en to the same word returns the old data.
- req_pc[1:0] != 0 -> resp_err=1, resp_inst=32'h0000_0013 (NOP).
- Index outside 0..DEPTH_WORDS-1, including req_pc < ADDR_BASE -> resp_err=1, resp_inst=32'h0000_0013. Misaligned takes priority when both apply (same outputs either way).
- Latency: request accepted at edge E, FIFO empty and no backpressure -> resp_valid=1 after edge E+LATENCY-1 (LATENCY=1: visible in the cycle after E). Back-to-back accepts give one response per cycle.
- Ordering: strictly in order. Head holds resp_* stable while resp_valid && !resp_ready.
- Backpressure: in-flight entries always have FIFO space, because the credit check counts them. Overflow is impossible; dropping an entry is a bug.
- flush=1 at an edge: all pipeline valids and FIFO entries cleared, count=0, resp_valid=0 next cycle, no accept that edge. Pop is ignored.
- Register resp_* outputs when FIFO_DEPTH allows; otherwise drive them from the FIFO head register. Either way no combinational path from req_* to resp_*.

Decomposition:
- Shared defines file: `INST_BUS (31:0), `INST_NOP 32'h0000_0013, and reuse of existing `REG_BUS / `ZERO_WORD.
- One sub-module, if_resp_fifo: synchronous FIFO, FIFO_DEPTH x {err, pc[63:0], inst[31:0]}, with push/pop/flush/empty/full.
- Top level holds the array, the latency shift pipeline and the credit counter.

Test Plan:
- Preload word 0 = 64'h0010_0093_0000_0013; fetch 0x8000_0000 then 0x8000_0004 back-to-back, resp_ready=1 -> responses 0x0000_0013 then 0x0010_0093, each LATENCY cycles after its accept, err=0.
- Fetch 0x8000_0002 -> err=1, inst=0x13. Fetch 0x8000_2000 (index 1024) -> err=1, inst=0x13.
- Hold resp_ready=0 and issue requests continuously -> exactly 4 accepted, req_ready=0. Release -> 4 in-order responses, then req_ready=1.
- Assert flush with 3 outstanding -> resp_valid=0 the next cycle, count=0, none of the 3 ever return. A new fetch returns normally.
- ld_en to word 5 on the same edge as accepting a fetch of 0x8000_0028 -> old data returned. Repeat the fetch -> new data.
- Assert rst low mid-stream with 2 in flight -> outputs zero immediately (async), req_ready=1 after release, no stale responses.
